// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: opcodes, FSM states and bus bit positions shared by the cpu_mc core.
package cpu_mc_pkg;
  typedef enum logic [2:0] {S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HLT} state_t;
  typedef struct packed {logic z; logic c;} flags_t;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_BEQ = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam int CTRL_RD  = 0;
  localparam int CTRL_WR  = 1;
  localparam int STAT_ACK = 0;
  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_BEQ || op == OP_HLT;
  endfunction
endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: register file with two async read ports, one sync write port and r0 tied to zero.
module cpu_regfile #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [3:0]            waddr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [3:0]            raddr1,
  input  logic [3:0]            raddr2,
  output logic [WORD_WIDTH-1:0] rdata1,
  output logic [WORD_WIDTH-1:0] rdata2
);
  localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [4:0] NR = 5'(NUM_REGS);
  logic [WORD_WIDTH-1:0] regs [NUM_REGS];
  assign rdata1 = {1'b0, raddr1} < NR ? regs[raddr1[AW-1:0]] : '0;
  assign rdata2 = {1'b0, raddr2} < NR ? regs[raddr2[AW-1:0]] : '0;
  // regs[0] is never written, so it keeps its reset value of zero
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (we && waddr != 4'd0 && {1'b0, waddr} < NR)
      regs[waddr[AW-1:0]] <= wdata;
endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle fetch/decode/execute/memory/writeback core mastering the mobo req/ack bus.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter logic [WORD_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    BUS_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [WORD_WIDTH-1:0] mobo_ctrl,
  input  logic [WORD_WIDTH-1:0] mobo_stat,
  output logic [WORD_WIDTH-1:0] addr,
  output logic [WORD_WIDTH-1:0] mobodat_out,
  input  logic [WORD_WIDTH-1:0] mobodat_in,
  output logic                  halted,
  output logic                  err
);
  localparam logic [4:0] NR = 5'(NUM_REGS);
  localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);
  state_t state, state_nx;
  flags_t flags;
  logic [31:0] ir, tcnt;
  logic [WORD_WIDTH-1:0] pc, ea, mdr, sext, rdata1, rdata2, alu, wdata;
  logic [WORD_WIDTH:0] sum, diff;
  logic [3:0] op, rd, rs1, rs2;
  logic ack, req, tmo, bad, is_ld, is_mem, alu_op, we, unused;
  assign {op, rd, rs1, rs2} = ir[31:16];
  assign sext   = {{(WORD_WIDTH-16){ir[15]}}, ir[15:0]};
  assign ack    = mobo_stat[STAT_ACK];
  assign req    = state == S_FETCH || state == S_MEM;
  assign tmo    = BUS_TIMEOUT != 0 && tcnt == 32'(BUS_TIMEOUT - 1);
  assign bad    = !op_legal(op) || {1'b0, rd} >= NR || {1'b0, rs1} >= NR || {1'b0, rs2} >= NR;
  assign is_ld  = op == OP_LD;
  assign is_mem = op == OP_LD || op == OP_ST;
  assign alu_op = op >= OP_ADD && op <= OP_LDI;
  assign sum    = {1'b0, rdata1} + {1'b0, rdata2};
  assign diff   = {1'b0, rdata1} - {1'b0, rdata2};
  assign we     = (state == S_EXEC && alu_op) || state == S_WB;
  assign wdata  = state == S_WB ? mdr : alu;
  assign unused = ^{mobo_stat[WORD_WIDTH-1:1], flags};
  always_comb
    alu = op == OP_ADD ? sum[WORD_WIDTH-1:0] :
          op == OP_SUB ? diff[WORD_WIDTH-1:0] :
          op == OP_AND ? rdata1 & rdata2 :
          op == OP_OR  ? rdata1 | rdata2 :
          op == OP_XOR ? rdata1 ^ rdata2 :
                         {{(WORD_WIDTH-16){1'b0}}, ir[15:0]};
  cpu_regfile #(.WORD_WIDTH(WORD_WIDTH), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk(clk), .rst(rst), .we(we), .waddr(rd), .wdata(wdata),
    .raddr1(rs1), .raddr2(rs2), .rdata1(rdata1), .rdata2(rdata2)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_RESET;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_RESET:  state_nx = S_FETCH;
      S_FETCH:  state_nx = ack ? S_DECODE : tmo ? S_HLT : S_FETCH;
      S_DECODE: state_nx = bad ? S_HLT : S_EXEC;
      S_EXEC:   state_nx = is_mem ? S_MEM : op == OP_HLT ? S_HLT : S_FETCH;
      S_MEM:    state_nx = ack ? (is_ld ? S_WB : S_FETCH) : tmo ? S_HLT : S_MEM;
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = S_HLT;
    endcase
  end
  // tcnt counts consecutive unacknowledged req cycles and clears on any other cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ir <= '0;
      pc <= RESET_PC;
      ea <= '0;
      mdr <= '0;
      tcnt <= '0;
      flags <= '0;
      err <= 1'b0;
    end else begin
      tcnt <= req && !ack && !tmo ? tcnt + 32'd1 : '0;
      if ((req && !ack && tmo) || (state == S_DECODE && bad)) err <= 1'b1;
      if (state == S_FETCH && ack) ir <= mobodat_in[31:0];
      if (state == S_MEM && ack) begin
        if (is_ld) mdr <= mobodat_in;
        else pc <= pc + ONE;
      end
      if (state == S_WB) pc <= pc + ONE;
      if (state == S_EXEC) begin
        ea <= rdata1 + sext;
        if (op == OP_BEQ) pc <= pc + ONE + (rdata1 == rdata2 ? sext : '0);
        else if (!is_mem && op != OP_HLT) pc <= pc + ONE;
        flags <= op == OP_ADD ? {sum[WORD_WIDTH-1:0] == '0, sum[WORD_WIDTH]} :
                 op == OP_SUB ? {diff[WORD_WIDTH-1:0] == '0, diff[WORD_WIDTH]} :
                 op == OP_AND || op == OP_OR || op == OP_XOR ? {alu == '0, flags.c} : flags;
      end
    end
  always_comb begin
    mobo_ctrl = '0;
    mobo_ctrl[CTRL_RD] = state == S_FETCH || (state == S_MEM && is_ld);
    mobo_ctrl[CTRL_WR] = state == S_MEM && !is_ld;
  end
  assign addr        = state == S_FETCH ? pc : state == S_MEM ? ea : '0;
  assign mobodat_out = state == S_MEM && !is_ld ? rdata2 : '0;
  assign halted      = state == S_HLT;
endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: randomized and directed programs checked against an ISA-level model through a bus scoreboard.
module tb_cpu_mc;
  typedef struct {logic wr; logic [31:0] addr; logic [31:0] data;} txn_t;
  localparam logic [31:0] HLT = 32'hF000_0000;
  logic clk = 0, rst = 0;
  logic [31:0] mobo_ctrl, mobo_stat, addr, mobodat_out, mobodat_in;
  logic halted, err;
  int n_chk = 0, n_fail = 0, waits = 0, wmode = 0, exp_cyc, cnt;
  bit exp_halt, exp_err;
  logic [31:0] slow_addr = '1;
  logic [31:0] img [256];
  logic [31:0] mm [256];
  logic [31:0] rmem [256];
  int ops [11] = '{0, 1, 2, 3, 4, 5, 6, 6, 7, 8, 9};
  txn_t exp_q [$];
  txn_t t;
  always #5 clk = ~clk;
  cpu_mc #(.WORD_WIDTH(32), .NUM_REGS(8), .RESET_PC(32'h0), .BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mobo_ctrl(mobo_ctrl), .mobo_stat(mobo_stat), .addr(addr),
    .mobodat_out(mobodat_out), .mobodat_in(mobodat_in), .halted(halted), .err(err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] ins(input int op, input int rd, input int s1, input int s2, input int imm);
    return {op[3:0], rd[3:0], s1[3:0], s2[3:0], imm[15:0]};
  endfunction
  // Memory slave: picks a wait count per request, acks, and applies writes at the ack
  initial begin
    bit in_txn = 0;
    int w = 0, wc = 0;
    mobo_stat = 0;
    mobodat_in = 0;
    forever begin
      @(posedge clk);
      #1;
      mobodat_in = $urandom;
      if (!rst || mobo_ctrl[1:0] == 2'b00) begin
        in_txn = 0;
        mobo_stat = $urandom & ~32'h1;
      end else begin
        if (!in_txn) begin
          in_txn = 1;
          wc = 0;
          w = wmode == 2 ? 1000 : addr == slow_addr ? 3 : wmode == 1 ? $urandom_range(0, 3) : 0;
        end
        if (wc == w) begin
          mobo_stat = $urandom | 32'h1;
          mobodat_in = rmem[addr[7:0]];
          if (mobo_ctrl[1]) rmem[addr[7:0]] = mobodat_out;
          in_txn = 0;
        end else begin
          mobo_stat = $urandom & ~32'h1;
          wc++;
          waits++;
        end
      end
    end
  end
  // Monitor: protocol checks every req cycle, scoreboard pop on every acked transfer
  initial begin
    logic prev_req = 0, prev_ack = 0;
    logic [31:0] prev_addr = 0, prev_ctrl = 0;
    forever begin
      @(negedge clk);
      if (!rst) prev_req = 0;
      else begin
        if (mobo_ctrl[1:0] != 2'b00) begin
          chk("rd_wr_exclusive", {31'b0, &mobo_ctrl[1:0]}, 32'h0);
          if (prev_req && !prev_ack) begin
            chk("addr_stable", addr, prev_addr);
            chk("ctrl_stable", mobo_ctrl, prev_ctrl);
          end
          if (mobo_stat[0]) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_txn: ctrl %h addr %h, none expected", mobo_ctrl, addr);
            end else begin
              t = exp_q.pop_front();
              chk("txn_kind", mobo_ctrl, t.wr ? 32'h2 : 32'h1);
              chk("txn_addr", addr, t.addr);
              if (t.wr) chk("txn_wdata", mobodat_out, t.data);
            end
          end
        end
        prev_req = |mobo_ctrl[1:0];
        prev_ack = mobo_stat[0];
        prev_addr = addr;
        prev_ctrl = mobo_ctrl;
      end
    end
  end
  // ISA-level reference: interprets the program and lists the bus transfers it must produce
  task automatic model(input int max_steps);
    logic [31:0] r [16];
    logic [31:0] pc, i, a, b, se, ea;
    int op, rd, s1, s2;
    foreach (r[k]) r[k] = 0;
    foreach (mm[k]) mm[k] = img[k];
    pc = 0;
    exp_cyc = 0;
    exp_halt = 0;
    exp_err = 0;
    for (int n = 0; n < max_steps; n++) begin
      i = mm[pc[7:0]];
      exp_q.push_back('{1'b0, pc, 32'h0});
      op = int'(i[31:28]); rd = int'(i[27:24]); s1 = int'(i[23:20]); s2 = int'(i[19:16]);
      se = {{16{i[15]}}, i[15:0]};
      a = r[s1];
      b = r[s2];
      if ((op > 9 && op != 15) || rd >= 8 || s1 >= 8 || s2 >= 8) begin
        exp_cyc += 2;
        exp_halt = 1;
        exp_err = 1;
        break;
      end
      exp_cyc += op == 7 ? 5 : op == 8 ? 4 : 3;
      if (op == 15) begin
        exp_halt = 1;
        break;
      end
      ea = a + se;
      case (op)
        1: r[rd] = a + b;
        2: r[rd] = a - b;
        3: r[rd] = a & b;
        4: r[rd] = a | b;
        5: r[rd] = a ^ b;
        6: r[rd] = {16'h0, i[15:0]};
        7: begin exp_q.push_back('{1'b0, ea, 32'h0}); r[rd] = mm[ea[7:0]]; end
        8: begin exp_q.push_back('{1'b1, ea, b}); mm[ea[7:0]] = b; end
        default: ;
      endcase
      r[0] = 0;
      pc = op == 9 && a == b ? pc + 1 + se : pc + 1;
    end
  endtask
  task automatic run_test(input int max_steps);
    exp_q.delete();
    model(max_steps);
    foreach (rmem[k]) rmem[k] = img[k];
    rst = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", mobo_ctrl | addr | mobodat_out | {30'b0, halted, err}, 32'h0);
    waits = 0;
    rst = 1;
    @(negedge clk);
    cnt = 0;
    if (exp_halt) begin
      while (!halted && cnt < 3000) begin
        @(negedge clk);
        cnt++;
      end
      chk("halted", {31'b0, halted}, 32'h1);
      chk("err", {31'b0, err}, {31'b0, exp_err});
      chk("cycles", cnt, exp_cyc + waits);
      repeat (3) begin
        @(negedge clk);
        chk("no_req_after_halt", mobo_ctrl, 32'h0);
      end
    end else begin
      while (cnt < exp_cyc - 1) begin
        @(negedge clk);
        cnt++;
      end
      #1 rst = 0;
    end
    #1 chk("txn_remaining", exp_q.size(), 32'h0);
  endtask
  task automatic clear_img();
    foreach (img[k]) img[k] = k >= 128 ? $urandom : HLT;
  endtask
  initial begin
    clear_img();
    img[0] = ins(6, 1, 0, 0, 5); img[1] = ins(6, 2, 0, 0, 6); img[2] = ins(1, 3, 1, 2, 0);
    img[3] = ins(8, 0, 0, 3, 'h40); img[4] = HLT;
    run_test(100);
    chk("sum_program_cycles", cnt, 32'd16);
    clear_img();
    img[0] = ins(6, 1, 0, 0, 1); img[1] = ins(2, 2, 0, 1, 0); img[2] = ins(8, 0, 0, 2, 'h41);
    img[3] = ins(2, 2, 1, 1, 0); img[4] = ins(8, 0, 0, 2, 'h42);
    run_test(100);
    clear_img();
    slow_addr = 7;
    img[7] = 32'hDEADBEEF;
    img[0] = ins(7, 4, 0, 0, 7); img[1] = ins(8, 0, 0, 4, 'h40);
    run_test(100);
    chk("slow_ld_cycles", cnt, 32'd15);
    slow_addr = '1;
    clear_img();
    img[0] = 0; img[1] = 0; img[2] = ins(9, 0, 0, 0, 'hFFFF);
    run_test(6);
    clear_img();
    img[0] = ins(6, 1, 0, 0, 1); img[1] = ins(9, 0, 0, 1, 5); img[2] = ins(8, 0, 0, 1, 'h40);
    img[3] = ins(9, 0, 1, 1, 1); img[4] = ins(8, 0, 0, 1, 'h41); img[5] = ins(8, 0, 0, 1, 'h42);
    run_test(100);
    clear_img();
    img[0] = ins(6, 1, 0, 0, 3); img[1] = 32'hA000_0000;
    run_test(100);
    clear_img();
    img[0] = ins(6, 12, 0, 0, 1);
    run_test(100);
    exp_q.delete();
    wmode = 2;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("fetch_req", mobo_ctrl, 32'h1);
    @(posedge clk);
    #2 rst = 0;
    #1 chk("reset_drops_req", mobo_ctrl, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    cnt = 0;
    while (!halted && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_cycles", cnt, 32'd4);
    chk("timeout_err", {31'b0, err}, 32'h1);
    @(negedge clk);
    chk("timeout_no_req", mobo_ctrl, 32'h0);
    wmode = 1;
    for (int p = 0; p < 12; p++) begin
      clear_img();
      for (int k = 0; k < 12; k++) begin
        int rr, op, imm;
        rr = $urandom_range(0, 99);
        op = ops[$urandom_range(0, 10)];
        imm = op == 7 || op == 8 ? $urandom_range(128, 255) : op == 9 ? $urandom_range(0, 2) : $urandom;
        if (rr < 3) img[k] = ins($urandom_range(10, 14), 1, 1, 1, 0);
        else if (rr < 5) img[k] = ins(1, $urandom_range(8, 15), 1, 1, 0);
        else img[k] = ins(op, $urandom_range(0, 7), op == 7 || op == 8 ? 0 : $urandom_range(0, 7),
                          $urandom_range(0, 7), imm);
      end
      run_test(200);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
